booth_pp_accumulator: RTL and testbench
=======================================

# booth_pp_accumulator

Sequential partial-product accumulator that sits directly downstream of the 16x16 classic (radix-2) Booth PP generator. It captures the sixteen 16-bit signed partial products and their sign bits in one handshake, then sums them in groups of `PP_PER_CYCLE` per clock. It presents the 32-bit two's-complement product on a valid/ready output port. Together with the generator it forms the multicycle signed multiplier datapath.

## Interface
- `PP_PER_CYCLE`, default 4: partial products summed per accumulate cycle; legal values are 1, 2, 4, 8, 16.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: PP bundle valid.
- `in_ready` out 1: block can accept a bundle.
- `pp_in` in 256: `pp_i` occupies bits `[16i+15:16i]`, for i = 0..15.
- `s_in` in 16: sign-extension bit of each PP; `s_in[i]` pairs with `pp_i`.
- `out_valid` out 1: `product` is valid.
- `out_ready` in 1: consumer accepts `product`.
- `product` out 32: accumulated signed product.
- `sign_err` out 1: sticky sign-mismatch flag. Exists only under `BOOTH_ACC_SIGNCHK_EN`; otherwise tied to 0.

## Operation
- Arithmetic: `product = Σ_{i=0..15} ({ {16{s_in[i]}}, pp_i } << i) mod 2^32`.
  - The sign extension uses `s_in[i]`, not `pp_i[15]`.
  - Accumulator and adders are 32 bits wide; carries out of bit 31 are discarded.
- The block sums exactly what it receives. With multiplicand −32768, the generator's negation wraps to 0x8000, and the block sums that value unchanged. No correction is applied.
- State machine:
  - IDLE:
    - `in_ready` = 1.
    - On `in_valid && in_ready`, register `pp_in` and `s_in`, clear the accumulator and `cnt`, then go to ACCUM.
  - ACCUM:
    - `in_ready` = 0.
    - Each cycle adds PPs with indices `cnt*P` through `cnt*P+P-1` to the accumulator and increments `cnt`.
    - After group `16/P - 1`, go to DONE.
  - DONE:
    - `out_valid` = 1 and `product` = accumulator.
    - Both are held stable until `out_ready`; then go to IDLE.
- `cnt` width is `clog2(16/P)`, with a minimum of 1 bit. With `P=16`, ACCUM lasts exactly one cycle.
- `in_valid` while not in IDLE is ignored; the bundle must be held by the producer.
- Output handshake is standard: transfer on `out_valid && out_ready`. `out_ready` may be high before `out_valid`.

## Timing
- Reset (`rst_n` = 0 at a rising edge) forces:
  - state IDLE, `in_ready` = 1, `out_valid` = 0;
  - `product` = 0, `sign_err` = 0, `cnt` = 0, internal PP registers = 0.
- Reset asserted mid-ACCUM or in DONE aborts the operation. The result is lost and no `out_valid` is produced.
- Latency, with accept at edge k:
  - ACCUM occupies edges k+1 through k+16/P;
  - `out_valid` goes high after edge k+16/P. Default P=4 gives 4 cycles.
- Throughput: one product per `16/P + 2` cycles when `out_ready` is held high. DONE→IDLE takes one edge, and accept takes one edge.
- `in_ready` goes low the cycle after acceptance. It goes high again the cycle after the output transfer.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `BOOTH_ACC_SIGNCHK_EN` defined:
  - At capture, the block compares each `s_in[i]` with `pp_in[16i+15]`.
  - Any mismatch sets `sign_err`, which stays set until reset.
  - The product is still computed with `s_in`.
- `BOOTH_ACC_SIGNCHK_EN` undefined: no compare logic is built, and `sign_err` is constant 0.

## Structure
- Package `booth_acc_pkg` holds:
  - constants `PP_W=16`, `NUM_PP=16`, `PROD_W=32`;
  - state enum `{IDLE, ACCUM, DONE}`;
  - helper function for sign-extending and shifting one PP to 32 bits.
- One sub-module, `booth_pp_group_adder`:
  - combinational;
  - takes P sign-extended PPs, the base index and the current accumulator;
  - returns the new 32-bit sum.
- The top level holds the FSM, counter, capture registers and output register.

## Test plan
- PP bundle for M=3, R=5 (`pp0`=−3, `pp1`=+3, `pp2`=−3, `pp3`=+3, rest 0) → `product`=32'h0000000F exactly 4 cycles after accept.
- M=0x7FFF, R=0x7FFF bundle → 32'h3FFF0001. M=0xFFFF, R=0xFFFF bundle → 32'h00000001.
- M=0x8000, R=0x8000 bundle (`pp15`=0x8000, `s_in[15]`=1, rest 0) → 32'hC0000000 (wrapped value, no correction).
- Hold `out_ready` low for 3 cycles in DONE → `product` and `out_valid` stay stable and `in_ready`=0. A second bundle offered meanwhile is accepted only after the transfer.
- Assert `rst_n`=0 for one cycle at ACCUM cycle 2 → all outputs return to reset values, no `out_valid`, and the next bundle yields the correct product.
- With `BOOTH_ACC_SIGNCHK_EN`: `s_in[5]`=0 while `pp5`=0x8001 → `sign_err`=1 and it stays set through later clean bundles until reset. Without the macro, `sign_err`=0 for the same stimulus.

Source files
------------

// File: rtl/booth_acc_pkg.sv
// Shared constants, FSM state type and PP alignment helper for the Booth
// partial-product accumulator.
package booth_acc_pkg;

  localparam int PP_W   = 16;
  localparam int NUM_PP = 16;
  localparam int PROD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Sign-extend one PP with its explicit sign bit, then weight it by 2^sh.
  function automatic logic [PROD_W-1:0] pp_extend_shift(
    input logic [PP_W-1:0] pp,
    input logic            s,
    input logic [3:0]      sh
  );
    logic [PROD_W-1:0] ext;
    ext = {{(PROD_W-PP_W){s}}, pp};
    return ext << sh;
  endfunction

endpackage

// File: rtl/booth_pp_accumulator_group_adder.sv
// Combinational adder: folds one group of P partial products (with their
// sign bits) into the running 32-bit accumulator.
module booth_pp_group_adder
  import booth_acc_pkg::*;
#(
  parameter int P = 4
) (
  input  logic [P*PP_W-1:0] grp_pp,
  input  logic [P-1:0]      grp_s,
  input  logic [3:0]        base_idx,
  input  logic [PROD_W-1:0] acc,
  output logic [PROD_W-1:0] sum
);

  logic [PROD_W-1:0] term [P];

  genvar gi;
  generate
    for (gi = 0; gi < P; gi++) begin : g_term
      // Weight of each PP is its absolute index within the bundle.
      assign term[gi] = pp_extend_shift(grp_pp[gi*PP_W +: PP_W], grp_s[gi],
                                        base_idx + 4'(gi));
    end
  endgenerate

  always_comb begin
    sum = acc;
    for (int j = 0; j < P; j++) begin
      sum = sum + term[j];
    end
  end

endmodule

// File: rtl/booth_pp_accumulator.sv
// Multicycle accumulator for sixteen radix-2 Booth partial products.
// Optional sticky sign-consistency check under BOOTH_ACC_SIGNCHK_EN.
module booth_pp_accumulator
  import booth_acc_pkg::*;
#(
  parameter int PP_PER_CYCLE = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_PP*PP_W-1:0] pp_in,
  input  logic [NUM_PP-1:0]      s_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PROD_W-1:0]      product,
  output logic                   sign_err
);

  localparam int GROUPS = NUM_PP / PP_PER_CYCLE;
  localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GROUPS - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [PROD_W-1:0] acc_reg, acc_next;
  logic [PROD_W-1:0] product_reg, product_next;
  logic              in_ready_reg, in_ready_next;
  logic              out_valid_reg, out_valid_next;
  logic              capture;

  logic [PP_W-1:0]   pp_reg [NUM_PP];
  logic [NUM_PP-1:0] s_reg;

  logic [3:0]                   base_idx;
  logic [PP_PER_CYCLE*PP_W-1:0] grp_pp;
  logic [PP_PER_CYCLE-1:0]      grp_s;
  logic [PROD_W-1:0]            group_sum;

  assign base_idx = 4'(cnt_reg * PP_PER_CYCLE);

  genvar gi;
  generate
    for (gi = 0; gi < PP_PER_CYCLE; gi++) begin : g_sel
      assign grp_pp[gi*PP_W +: PP_W] = pp_reg[base_idx + 4'(gi)];
      assign grp_s[gi]               = s_reg[base_idx + 4'(gi)];
    end
  endgenerate

  booth_pp_group_adder #(
    .P (PP_PER_CYCLE)
  ) u_group_adder (
    .grp_pp   (grp_pp),
    .grp_s    (grp_s),
    .base_idx (base_idx),
    .acc      (acc_reg),
    .sum      (group_sum)
  );

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    acc_next       = acc_reg;
    product_next   = product_reg;
    in_ready_next  = in_ready_reg;
    out_valid_next = out_valid_reg;
    capture        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid && in_ready_reg) begin
          capture       = 1'b1;
          acc_next      = '0;
          cnt_next      = '0;
          in_ready_next = 1'b0;
          state_next    = ACCUM;
        end
      end
      ACCUM: begin
        acc_next = group_sum;
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == LAST_CNT) begin
          // Load the output register with the final sum directly so
          // out_valid and product rise together.
          product_next   = group_sum;
          out_valid_next = 1'b1;
          state_next     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          in_ready_next  = 1'b1;
          state_next     = IDLE;
        end
      end
      default: begin
        out_valid_next = 1'b0;
        in_ready_next  = 1'b1;
        state_next     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      product_reg   <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      s_reg         <= '0;
      for (int i = 0; i < NUM_PP; i++) begin
        pp_reg[i] <= '0;
      end
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      acc_reg       <= acc_next;
      product_reg   <= product_next;
      in_ready_reg  <= in_ready_next;
      out_valid_reg <= out_valid_next;
      if (capture) begin
        s_reg <= s_in;
        for (int i = 0; i < NUM_PP; i++) begin
          pp_reg[i] <= pp_in[i*PP_W +: PP_W];
        end
      end
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign product   = product_reg;

`ifdef BOOTH_ACC_SIGNCHK_EN
  logic [NUM_PP-1:0] sign_mismatch;
  logic              sign_err_reg;

  generate
    for (gi = 0; gi < NUM_PP; gi++) begin : g_signchk
      assign sign_mismatch[gi] = s_in[gi] ^ pp_in[gi*PP_W + PP_W - 1];
    end
  endgenerate

  // Sticky until reset; only bundles actually captured are inspected.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sign_err_reg <= 1'b0;
    end else if (capture && (|sign_mismatch)) begin
      sign_err_reg <= 1'b1;
    end
  end

  assign sign_err = sign_err_reg;
`else
  assign sign_err = 1'b0;
`endif

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Scoreboard bench for booth_pp_accumulator: directed Booth bundles with
// hand-computed products, output handshake stalls, mid-operation reset.
module tb_booth_pp_accumulator;
  import booth_acc_pkg::*;

  localparam int P   = 4;
  localparam int LAT = 16 / P;
`ifdef BOOTH_ACC_SIGNCHK_EN
  localparam logic SIGN_EXP = 1'b1;
`else
  localparam logic SIGN_EXP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] pp_in = '0;
  logic [15:0]  s_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  product;
  logic         sign_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct packed {
    logic [31:0] prod;
    logic [31:0] acc_cyc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  booth_pp_accumulator #(.PP_PER_CYCLE(P)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pp_in     (pp_in),
    .s_in      (s_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .sign_err  (sign_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Emulates the radix-2 Booth generator to build stimulus bundles.
  function automatic void booth_bundle(input logic [15:0] m, input logic [15:0] r,
                                       output logic [255:0] pp, output logic [15:0] s);
    logic        prev;
    logic [15:0] v;
    pp = '0;
    s = '0;
    prev = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (r[i] && !prev) v = -m;
      else if (!r[i] && prev) v = m;
      else v = '0;
      pp[i*16 +: 16] = v;
      s[i] = v[15];
      prev = r[i];
    end
  endfunction

  // Monitor: latency on out_valid rise, product on every transfer.
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !prev_ov) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL spurious_valid: got out_valid=1 expected no pending bundle");
      end else begin
        check("latency", 32'(cyc) - sb[0].acc_cyc, 32'(LAT));
      end
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_output: got product=%h expected none", product);
      end else begin
        e = sb.pop_front();
        $display("xfer product=%h expected=%h cyc=%0d", product, e.prod, cyc);
        check("product", product, e.prod);
      end
    end
    prev_ov = out_valid;
  end

  task automatic offer(input logic [255:0] pp, input logic [15:0] s);
    @(posedge clk); #1;
    pp_in = pp;
    s_in = s;
    in_valid = 1'b1;
  endtask

  task automatic complete(input logic [31:0] exp_prod);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end else begin
      sb.push_back('{prod: exp_prod, acc_cyc: 32'(cyc + 1)});
      $display("accept pp=%h s=%h expected=%h", pp_in, s_in, exp_prod);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_ms(input logic [15:0] m, input logic [15:0] r, input logic [31:0] exp_prod);
    logic [255:0] pp;
    logic [15:0]  s;
    booth_bundle(m, r, pp, s);
    offer(pp, s);
    complete(exp_prod);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout: got pending=%0d expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_product"}, product, 32'd0);
    check({tag, "_sign_err"}, 32'(sign_err), 32'd0);
  endtask

  initial begin
    logic [255:0] pp;
    logic [15:0]  s;
    int           n;
    int           seen;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst_n = 1'b1;

    // Directed products
    send_ms(16'h0003, 16'h0005, 32'h0000000F);
    drain();
    send_ms(16'h7FFF, 16'h7FFF, 32'h3FFF0001);
    send_ms(16'hFFFF, 16'hFFFF, 32'h00000001);
    send_ms(16'h8000, 16'h8000, 32'hC0000000);
    send_ms(16'hFFF9, 16'h0009, 32'hFFFFFFC1);
    send_ms(16'h0064, 16'hFFFD, 32'hFFFFFED4);
    send_ms(16'h1234, 16'h0002, 32'h00002468);
    drain();

    // Output stall: hold out_ready low three cycles in DONE
    out_ready = 1'b0;
    send_ms(16'h0012, 16'h0034, 32'h000003A8);
    booth_bundle(16'h00FF, 16'h0101, pp, s);
    offer(pp, s);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_product", product, 32'h000003A8);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      if (i < 2) @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    complete(32'h0000FFFF);
    drain();

    // Reset during the second ACCUM cycle aborts the operation
    send_ms(16'h0003, 16'h0005, 32'h0000000F);
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset_state("abort");
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    send_ms(16'h0005, 16'h0006, 32'h0000001E);
    drain();

    // Sign-consistency flag: pp5 = 0x8001 with s_in[5] = 0
    check("sign_err_clean", 32'(sign_err), 32'd0);
    pp = '0;
    pp[5*16 +: 16] = 16'h8001;
    s = '0;
    offer(pp, s);
    complete(32'h00100020);
    drain();
    check("sign_err_set", 32'(sign_err), 32'(SIGN_EXP));
    send_ms(16'h0003, 16'h0005, 32'h0000000F);
    drain();
    check("sign_err_sticky", 32'(sign_err), 32'(SIGN_EXP));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("sign_err_after_reset", 32'(sign_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
